ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 30 +++
 rtl/ifetch_fifo.sv | 103 ++++++++++
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
//
// Shared definitions for the instruction fetch unit:
//   RESET_PC_DEFAULT - PC loaded on reset unless the top is overridden
//   DEPTH_DEFAULT    - default instruction buffer entry count
//   WORD_ALIGN_MASK  - clears the byte-offset bits of an address
//   FETCH_STRIDE     - PC increment per fetched word
//   PC8_OFFSET       - distance from fetch address to the ARM PC read value
//   fetch_entry_t    - one buffered fetch: instruction word plus its address
//   word_align()     - forces an address onto a 32-bit word boundary
// -----------------------------------------------------------------------------
package ifetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          DEPTH_DEFAULT    = 2;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] FETCH_STRIDE     = 32'd4;
   localparam logic [31:0] PC8_OFFSET       = 32'd8;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
//
// Synchronous FIFO of fetch_entry_t used as the fetch-to-decode buffer.
// Head data comes straight from storage, so an entry written at one edge is
// visible at the head from the next cycle on (no write-to-read bypass).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-low reset (0 = reset)
//   push       in   request to write push_data at the tail
//   push_data  in   entry to write
//   pop        in   request to remove the head entry
//   flush      in   discard every entry; overrides push and pop
//   head       out  entry at the head (undefined contents while empty)
//   full       out  occupancy equals DEPTH
//   empty      out  occupancy equals zero
//
// A push while full is accepted only when a pop happens in the same cycle,
// which leaves the occupancy unchanged.
// -----------------------------------------------------------------------------
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             do_push;
   logic             do_pop;
   logic             do_write;

   fetch_entry_t     mem_q [DEPTH];

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      do_write = do_push && !flush;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately left out of reset; its contents only
   // matter while the count says they are valid, and the top gates its
   // outputs with that.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage: owns the fetch PC, reads one word per cycle from a
// combinational instruction memory and queues {instr, pc} for decode.
// A redirect from execute has priority over fetching: it reloads the PC with
// the word-aligned target and flushes the buffer in the same edge.
//
// Parameters:
//   RESET_PC     PC loaded while reset is low
//   DEPTH        buffer entries (power of two, >= 2)
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-low reset; overrides br_valid
//   imem_a       out  instruction memory address (always the fetch PC)
//   imem_rd      in   instruction memory data for imem_a, same cycle
//   br_valid     in   redirect request
//   br_target    in   redirect address, byte-offset bits ignored
//   instr_valid  out  buffer head holds an instruction
//   instr_ready  in   decode takes the head this cycle
//   instr        out  instruction at the head
//   instr_pc     out  fetch address of instr
//   instr_pc8    out  instr_pc + 8 (ARM PC read value)
//
// While instr_valid is low the three head outputs read as zero, so they are
// clean after reset and never expose stale or uninitialised storage.
// -----------------------------------------------------------------------------
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc8
);

   logic [31:0]  pc_q, pc_d;
   logic         pop;
   logic         fetch;
   logic         fifo_full;
   logic         fifo_empty;
   fetch_entry_t fifo_head;
   fetch_entry_t fetch_entry;

   assign imem_a      = pc_q;
   assign instr_valid = !fifo_empty;

   always_comb begin
      pop               = instr_valid && instr_ready;
      // A fetch may land in a full buffer only when the head leaves this
      // cycle; a redirect suppresses the fetch of the now-wrong path.
      fetch             = !br_valid && (!fifo_full || pop);
      fetch_entry.instr = imem_rd;
      fetch_entry.pc    = pc_q;

      pc_d = pc_q;
      if (br_valid) begin
         pc_d = word_align(br_target);
      end else if (fetch) begin
         pc_d = pc_q + FETCH_STRIDE;  // wraps FFFF_FFFC -> 0000_0000
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   // A pop in the redirect cycle needs no special handling: the flush drops
   // the head together with everything behind it.
   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fetch),
      .push_data (fetch_entry),
      .pop       (pop),
      .flush     (br_valid),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      instr     = '0;
      instr_pc  = '0;
      instr_pc8 = '0;
      if (instr_valid) begin
         instr     = fifo_head.instr;
         instr_pc  = fifo_head.pc;
         instr_pc8 = fifo_head.pc + PC8_OFFSET;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Main DUT (RESET_PC = 0, DEPTH = 2) is compared every cycle against a queue
// model of the fetch buffer; directed literal expectations pin the model.
// A second DUT with RESET_PC = FFFF_FFF8 covers the PC wrap.
// The instruction memory returns 32'hE000_0000 | address.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam logic [31:0] IMEM_TAG      = 32'hE000_0000;
   localparam logic [31:0] RESET_PC_MAIN = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_WRAP = 32'hFFFF_FFF8;
   localparam int          TB_DEPTH      = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        br_valid;
   logic [31:0] br_target;
   logic        instr_ready;
   logic [31:0] imem_a, imem_rd;
   logic        instr_valid;
   logic [31:0] instr, instr_pc, instr_pc8;

   logic [31:0] imem_a_w, imem_rd_w;
   logic        instr_valid_w;
   logic [31:0] instr_w, instr_pc_w, instr_pc8_w;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (post-edge view)
   fetch_entry_t m_q[$];
   logic [31:0]  m_pc;
   logic         m_fresh;   // reset seen, nothing written since
   logic         cmp_en = 1'b0;

   always #5 clk = ~clk;

   assign imem_rd   = IMEM_TAG | imem_a;
   assign imem_rd_w = IMEM_TAG | imem_a_w;

   ifetch_unit #(.RESET_PC(RESET_PC_MAIN), .DEPTH(TB_DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_a      (imem_a),
      .imem_rd     (imem_rd),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_pc8   (instr_pc8)
   );

   ifetch_unit #(.RESET_PC(RESET_PC_WRAP), .DEPTH(TB_DEPTH)) dut_w (
      .clk         (clk),
      .reset       (reset),
      .imem_a      (imem_a_w),
      .imem_rd     (imem_rd_w),
      .br_valid    (1'b0),
      .br_target   (32'h0),
      .instr_valid (instr_valid_w),
      .instr_ready (1'b1),
      .instr       (instr_w),
      .instr_pc    (instr_pc_w),
      .instr_pc8   (instr_pc8_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock edge: apply the fetch rules to the model, then let outputs settle.
   task automatic tick();
      bit           was_full;
      bit           popped;
      fetch_entry_t e;
      @(posedge clk);
      if (!reset) begin
         m_q.delete();
         m_pc    = RESET_PC_MAIN;
         m_fresh = 1'b1;
      end else begin
         was_full = (m_q.size() >= TB_DEPTH);
         popped   = (m_q.size() != 0) && instr_ready;
         if (br_valid) begin
            m_q.delete();
            m_pc = {br_target[31:2], 2'b00};
         end else begin
            if (popped) void'(m_q.pop_front());
            if (!was_full || popped) begin
               e.instr = IMEM_TAG | m_pc;
               e.pc    = m_pc;
               m_q.push_back(e);
               m_pc    = m_pc + 32'd4;
               m_fresh = 1'b0;
            end
         end
      end
      #1;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_imem_a", imem_a, m_pc);
         check("cyc_instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            check("cyc_instr",     instr,     m_q[0].instr);
            check("cyc_instr_pc",  instr_pc,  m_q[0].pc);
            check("cyc_instr_pc8", instr_pc8, m_q[0].pc + 32'd8);
         end else if (m_fresh) begin
            check("cyc_instr_rst",     instr,     32'h0);
            check("cyc_instr_pc_rst",  instr_pc,  32'h0);
            check("cyc_instr_pc8_rst", instr_pc8, 32'h0);
         end
      end
   end

   initial begin
      logic [39:0] rdy_pat;
      reset       = 1'b0;
      br_valid    = 1'b0;
      br_target   = 32'h0;
      instr_ready = 1'b1;

      // Reset state
      tick();
      tick();
      cmp_en = 1'b1;
      check("rst_valid",   32'(instr_valid), 32'h0);
      check("rst_instr",   instr,     32'h0);
      check("rst_pc",      instr_pc,  32'h0);
      check("rst_pc8",     instr_pc8, 32'h0);
      check("rst_imem_a",  imem_a,    32'h0);
      check("rst_imem_aw", imem_a_w,  32'hFFFF_FFF8);

      // Streaming with ready=1, plus the wrapping instance
      reset = 1'b1;
      tick();
      check("s0_valid", 32'(instr_valid), 32'h1);
      check("s0_pc",    instr_pc,   32'h0000_0000);
      check("s0_instr", instr,      32'hE000_0000);
      check("s0_pc8",   instr_pc8,  32'h0000_0008);
      check("s0_imem",  imem_a,     32'h0000_0004);
      check("w0_pc",    instr_pc_w, 32'hFFFF_FFF8);
      tick();
      check("s1_pc",    instr_pc,    32'h0000_0004);
      check("s1_pc8",   instr_pc8,   32'h0000_000C);
      check("w1_pc",    instr_pc_w,  32'hFFFF_FFFC);
      check("w1_pc8",   instr_pc8_w, 32'h0000_0004);
      tick();
      check("s2_pc",    instr_pc,    32'h0000_0008);
      check("w2_pc",    instr_pc_w,  32'h0000_0000);
      check("w2_instr", instr_w,     32'hE000_0000);

      // Back-pressure from reset: buffer fills, PC freezes
      reset = 1'b0;
      tick();
      reset       = 1'b1;
      instr_ready = 1'b0;
      repeat (5) tick();
      check("bp_imem",  imem_a,   32'h0000_0008);
      check("bp_pc",    instr_pc, 32'h0000_0000);
      check("bp_instr", instr,    32'hE000_0000);
      check("bp_valid", 32'(instr_valid), 32'h1);
      instr_ready = 1'b1;
      tick();
      check("bp_r0_pc", instr_pc, 32'h0000_0004);
      tick();
      check("bp_r1_pc", instr_pc, 32'h0000_0008);
      tick();
      check("bp_r2_pc", instr_pc, 32'h0000_000C);

      // Redirect with two entries buffered
      instr_ready = 1'b0;
      tick();
      br_valid  = 1'b1;
      br_target = 32'h0000_0103;
      tick();
      check("br_valid_off", 32'(instr_valid), 32'h0);
      check("br_imem",      imem_a,           32'h0000_0100);
      br_valid    = 1'b0;
      instr_ready = 1'b1;
      tick();
      check("br_first_pc",  instr_pc, 32'h0000_0100);
      check("br_next_imem", imem_a,   32'h0000_0104);
      tick();

      // Redirect together with a pop
      br_valid  = 1'b1;
      br_target = 32'h0000_0200;
      tick();
      check("brpop_valid_off", 32'(instr_valid), 32'h0);
      br_valid = 1'b0;
      tick();
      check("brpop_pc",  instr_pc, 32'h0000_0200);
      tick();
      check("brpop_pc2", instr_pc, 32'h0000_0204);

      // Reset mid-stream overrides a redirect
      reset     = 1'b0;
      br_valid  = 1'b1;
      br_target = 32'h0000_0300;
      tick();
      check("mrst_valid", 32'(instr_valid), 32'h0);
      check("mrst_imem",  imem_a,           32'h0000_0000);
      reset    = 1'b1;
      br_valid = 1'b0;
      tick();
      check("mrst_pc",   instr_pc, 32'h0000_0000);
      check("mrst_imem2", imem_a,  32'h0000_0004);

      // Mixed ready pattern with redirects, one near the top of memory
      rdy_pat = 40'hB3_5C_E1_96_0F;
      for (int i = 0; i < 40; i++) begin
         instr_ready = rdy_pat[i];
         br_valid    = (i == 13) || (i == 27);
         br_target   = (i == 13) ? 32'h0000_7FF6 : 32'hFFFF_FFF7;
         tick();
      end
      br_valid    = 1'b0;
      instr_ready = 1'b1;
      repeat (4) tick();

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
